adder_req_arbiter: RTL
======================

ADDER_REQ_ARBITER -- requirements
Module: adder_req_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_IN_WIDTH, default 8, operand width.
REQ-002 The block SHALL have parameter TAG_DEPTH, default 4, maximum outstanding operations; power of two, >=2.
REQ-003 The block SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports reqN_a, reqN_b  input  DATA_IN_WIDTH  requester N operands, N in {0,1}.
REQ-006 The block SHALL have ports reqN_valid input 1 and reqN_ready output 1, the requester N operand handshake.
REQ-007 The block SHALL have port rspN_data  output  DATA_IN_WIDTH+1  requester N sum.
REQ-008 The block SHALL have ports rspN_valid output 1 and rspN_ready input 1, the requester N result handshake.
REQ-009 The block SHALL have ports op_a, op_b  output  DATA_IN_WIDTH  operands to the shared adder operand FIFOs.
REQ-010 The block SHALL have ports op_a_valid/op_b_valid output 1 and op_a_ready/op_b_ready input 1, independent per-operand handshakes.
REQ-011 The block SHALL have ports res_in input DATA_IN_WIDTH+1, res_in_valid input 1 and res_in_ready output 1, the shared result FIFO output.
REQ-012 The block SHALL have port err_o  output  1  sticky protocol error.

Function
REQ-013 Transfers SHALL occur on a rising clk_i edge when valid and ready are both high.
REQ-014 Issue stage: the block SHALL hold one registered operand pair with flags a_pend and b_pend; op_a_valid=a_pend and op_b_valid=b_pend.
REQ-015 Each flag SHALL clear independently on its own handshake; op_a/op_b SHALL stay stable while the corresponding flag is set.
REQ-016 Grant SHALL be possible only when a_pend=b_pend=0 and the tag FIFO is not full.
REQ-017 Arbitration SHALL be round-robin with last_grant register; if both reqN_valid, grant the requester != last_grant; if one valid, grant it.
REQ-018 reqN_ready SHALL be high only for the granted requester in that cycle; it SHALL NOT depend on reqN_valid of the same requester beyond arbitration.
REQ-019 On a grant handshake in cycle T, operands SHALL load into the issue stage, a_pend/b_pend SHALL be set at T+1, last_grant SHALL update, and the grant ID SHALL push into the tag FIFO.
REQ-020 The tag FIFO SHALL be TAG_DEPTH x 1 bit with wrap-around read/write pointers and an occupancy counter 0..TAG_DEPTH.
REQ-021 Result routing SHALL be combinational: with tag FIFO non-empty and head=N, rspN_valid=res_in_valid, rspN_data=res_in, res_in_ready=rspN_ready; the other rsp valid SHALL be 0.
REQ-022 On a res_in handshake the tag FIFO SHALL pop; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 With the tag FIFO empty, res_in_ready SHALL be 0 and both rspN_valid SHALL be 0; if res_in_valid=1 in that state, err_o SHALL set and remain set until reset.
REQ-024 Results SHALL return to requesters in grant order; no reordering or data modification.
REQ-025 A full tag FIFO SHALL deassert both reqN_ready until a pop occurs; a pop in the same cycle SHALL NOT enable a grant in that cycle.

Reset
REQ-026 While arst_n=0 the block SHALL asynchronously force a_pend=b_pend=0, tag occupancy=0, pointers=0, last_grant=1, err_o=0, and op_a=op_b=0.
REQ-027 With these values, op_a_valid, op_b_valid, rspN_valid, reqN_ready and res_in_ready SHALL be 0 during reset.
REQ-028 Reset asserted mid-operation SHALL discard pending operands and tags; the first grant after release SHALL go to requester 0.

Verification
REQ-029 req0 (3,5) alone; op readies high -> req0_ready at T, op_a=3/op_b=5 valid at T+1; res_in=8 -> rsp0_valid, rsp0_data=8, rsp1_valid=0.
REQ-030 Both requesters valid for 4 grants -> grant order 0,1,0,1; results return in the same order.
REQ-031 op_a_ready=1, op_b_ready=0 for 3 cycles -> op_a_valid drops after 1 cycle, op_b_valid held with stable op_b; no new grant until op_b accepted.
REQ-032 TAG_DEPTH=4, 4 grants with no results -> both reqN_ready=0; one res_in handshake -> a grant possible the following cycle.
REQ-033 rsp1_ready=0 with head tag=1 -> res_in_ready=0, tag FIFO unchanged; res_in_valid with empty tag FIFO -> err_o=1, sticky.
REQ-034 arst_n pulsed low with 2 outstanding tags and a_pend=1 -> all valids 0, occupancy 0, next grant to req0.

Source files
------------

// File: rtl/adder_req_arbiter.sv
// Two-requester front end for a shared adder: round-robin grant into a
// registered issue stage, with a tag FIFO that routes results back in grant order.
module adder_req_arbiter #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int TAG_DEPTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_n,
  input  logic [DATA_IN_WIDTH-1:0] req0_a,
  input  logic [DATA_IN_WIDTH-1:0] req0_b,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_IN_WIDTH-1:0] req1_a,
  input  logic [DATA_IN_WIDTH-1:0] req1_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  output logic [DATA_IN_WIDTH:0]   rsp0_data,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_IN_WIDTH:0]   rsp1_data,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_IN_WIDTH-1:0] op_a,
  output logic [DATA_IN_WIDTH-1:0] op_b,
  output logic                     op_a_valid,
  output logic                     op_b_valid,
  input  logic                     op_a_ready,
  input  logic                     op_b_ready,
  input  logic [DATA_IN_WIDTH:0]   res_in,
  input  logic                     res_in_valid,
  output logic                     res_in_ready,
  output logic                     err_o
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [DATA_IN_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_IN_WIDTH-1:0] op_b_q, op_b_d;
  logic                     a_pend_q, a_pend_d;
  logic                     b_pend_q, b_pend_d;
  logic                     last_grant_q, last_grant_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     err_q, err_d;
  logic                     run_q;
  logic [TAG_DEPTH-1:0]     tag_q;

  logic tag_full, tag_empty, can_grant;
  logic gnt0, gnt1, push, pop, head;

  // Grant and result routing are purely combinational on registered state.
  always_comb begin
    tag_full  = (count_q == FULL_CNT);
    tag_empty = (count_q == '0);
    // run_q keeps every ready low while reset is held and for the first edge after.
    can_grant = run_q && !a_pend_q && !b_pend_q && !tag_full;

    gnt1 = req1_valid && (!req0_valid || !last_grant_q);
    gnt0 = req0_valid && !gnt1;

    req0_ready = can_grant && gnt0;
    req1_ready = can_grant && gnt1;
    push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    head         = tag_q[rd_ptr_q];
    rsp0_data    = res_in;
    rsp1_data    = res_in;
    rsp0_valid   = !tag_empty && !head && res_in_valid;
    rsp1_valid   = !tag_empty &&  head && res_in_valid;
    res_in_ready = !tag_empty && (head ? rsp1_ready : rsp0_ready);
    pop          = res_in_valid && res_in_ready;

    op_a       = op_a_q;
    op_b       = op_b_q;
    op_a_valid = a_pend_q;
    op_b_valid = b_pend_q;
    err_o      = err_q;
  end

  // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    a_pend_d     = a_pend_q;
    b_pend_d     = b_pend_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q | (tag_empty && res_in_valid);

    if (op_a_valid && op_a_ready) a_pend_d = 1'b0;
    if (op_b_valid && op_b_ready) b_pend_d = 1'b0;

    if (push) begin
      op_a_d       = gnt1 ? req1_a : req0_a;
      op_b_d       = gnt1 ? req1_b : req0_b;
      a_pend_d     = 1'b1;
      b_pend_d     = 1'b1;
      last_grant_d = gnt1;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      a_pend_q     <= 1'b0;
      b_pend_q     <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      a_pend_q     <= a_pend_d;
      b_pend_q     <= b_pend_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      run_q        <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; count_q gates every read, so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push) tag_q[wr_ptr_q] <= gnt1;
  end

endmodule
